// File: rtl/instruction_aligner_pkg.sv
// Shared types and constants for the fetch-side instruction aligner.
// Halfwords are the unit of buffering; 32-bit instructions are identified by their low opcode bits.
package instruction_aligner_pkg;

   typedef logic [15:0] halfword_t;
   typedef logic [31:0] instruction_type;

   localparam logic [1:0]  RVC_OPCODE_32 = 2'b11;
   localparam int unsigned HW_DEPTH      = 4;

   function automatic logic is_compressed(input halfword_t hw);
      return hw[1:0] != RVC_OPCODE_32;
   endfunction

endpackage

// File: rtl/instruction_aligner_buffer.sv
// Four-entry halfword shift buffer: pops 0/1/2 entries from the head and
// appends 0/1/2 entries after whatever remains, all in one cycle.
module halfword_buffer
   import instruction_aligner_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_clear,
   input  logic [1:0] i_push_count,
   input  halfword_t  i_push_hw0,
   input  halfword_t  i_push_hw1,
   input  logic [1:0] i_pop_count,
   output halfword_t  o_hw0,
   output halfword_t  o_hw1,
   output logic [2:0] o_occ
);

   halfword_t [HW_DEPTH-1:0] r_hw;
   halfword_t [HW_DEPTH-1:0] w_hw_next;
   logic [2:0]               r_occ;
   logic [2:0]               w_rem;
   logic [2:0]               w_occ_next;

   assign w_rem      = r_occ - {1'b0, i_pop_count};
   assign w_occ_next = w_rem + {1'b0, i_push_count};

   genvar gi;
   generate
      for (gi = 0; gi < HW_DEPTH; gi++) begin : g_slot
         halfword_t  w_shift1;
         halfword_t  w_shift2;
         halfword_t  w_next;
         logic [2:0] w_slot;

         if (gi + 1 < HW_DEPTH) begin : g_s1
            assign w_shift1 = r_hw[gi+1];
         end else begin : g_z1
            assign w_shift1 = '0;
         end

         if (gi + 2 < HW_DEPTH) begin : g_s2
            assign w_shift2 = r_hw[gi+2];
         end else begin : g_z2
            assign w_shift2 = '0;
         end

         // Position of this slot relative to the first free entry after the pop
         assign w_slot = 3'(gi) - w_rem;

         always_comb begin
            case (i_pop_count)
               2'd0:    w_next = r_hw[gi];
               2'd1:    w_next = w_shift1;
               default: w_next = w_shift2;
            endcase
            if ((3'(gi) >= w_rem) && (w_slot < {1'b0, i_push_count})) begin
               w_next = (w_slot == 3'd0) ? i_push_hw0 : i_push_hw1;
            end
         end

         assign w_hw_next[gi] = w_next;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_occ <= '0;
         r_hw  <= '0;
      end else begin
         r_occ <= w_occ_next;
         r_hw  <= w_hw_next;
      end
   end

   assign o_hw0 = r_hw[0];
   assign o_hw1 = r_hw[1];
   assign o_occ = r_occ;

endmodule

// File: rtl/instruction_aligner.sv
// Fetch realignment stage: word requests to a 1-cycle BRAM, halfword buffering,
// and one 16- or 32-bit instruction per cycle with its PC and compressed flag.
module instruction_aligner
   import instruction_aligner_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          ADDR_WIDTH = 32
)
(
   input  logic                  clk,
   input  logic                  reset,
   output logic                  imem_req_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   input  logic [31:0]           imem_rdata_i,
   input  logic                  flush_i,
   input  logic [31:0]           flush_pc_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [31:0]           out_instr_o,
   output logic [31:0]           out_pc_o,
   output logic                  out_compressed_o
);

   localparam logic [ADDR_WIDTH-1:0] FETCH_RESET = ADDR_WIDTH'(RESET_PC & ~32'h3);

   logic [31:0]           r_pc;
   logic [ADDR_WIDTH-1:0] r_fetch_addr;
   logic                  r_drop_low;
   logic                  r_rsp_pending;

   halfword_t       w_hw0;
   halfword_t       w_hw1;
   logic [2:0]      w_occ;
   logic            w_is_c;
   logic            w_avail;
   logic            w_fire;
   logic [1:0]      w_pop_count;
   logic [1:0]      w_push_count;
   halfword_t       w_push_hw0;
   logic [3:0]      w_proj;
   instruction_type w_instr;

   halfword_buffer u_buf (
      .clk          (clk),
      .reset        (reset),
      .i_clear      (flush_i),
      .i_push_count (w_push_count),
      .i_push_hw0   (w_push_hw0),
      .i_push_hw1   (imem_rdata_i[31:16]),
      .i_pop_count  (w_pop_count),
      .o_hw0        (w_hw0),
      .o_hw1        (w_hw1),
      .o_occ        (w_occ)
   );

   always_comb begin
      w_is_c  = is_compressed(w_hw0);
      w_avail = (w_occ != 3'd0) && (w_is_c || (w_occ >= 3'd2));
      w_instr = '0;
      if (w_occ != 3'd0) begin
         w_instr = w_is_c ? {16'h0000, w_hw0} : {w_hw1, w_hw0};
      end
   end

   assign out_valid_o      = w_avail && !flush_i && !reset;
   assign out_instr_o      = w_instr;
   assign out_compressed_o = (w_occ != 3'd0) && w_is_c;
   assign out_pc_o         = r_pc;

   assign w_fire       = out_valid_o && out_ready_i;
   assign w_pop_count  = w_fire ? (w_is_c ? 2'd1 : 2'd2) : 2'd0;
   // A response whose low halfword precedes the target PC contributes only its high half
   assign w_push_count = r_rsp_pending ? (r_drop_low ? 2'd1 : 2'd2) : 2'd0;
   assign w_push_hw0   = r_drop_low ? imem_rdata_i[31:16] : imem_rdata_i[15:0];

   // Only request when the response is guaranteed to fit after next cycle's push
   assign w_proj      = {1'b0, w_occ} - {2'b00, w_pop_count} + {2'b00, w_push_count};
   assign imem_req_o  = !flush_i && !reset && (w_proj <= 4'd2);
   assign imem_addr_o = r_fetch_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc          <= RESET_PC;
         r_fetch_addr  <= FETCH_RESET;
         r_drop_low    <= RESET_PC[1];
         r_rsp_pending <= 1'b0;
      end else if (flush_i) begin
         r_pc          <= flush_pc_i;
         r_fetch_addr  <= ADDR_WIDTH'(flush_pc_i & ~32'h3);
         r_drop_low    <= flush_pc_i[1];
         r_rsp_pending <= 1'b0;
      end else begin
         if (w_fire) begin
            r_pc <= r_pc + (w_is_c ? 32'd2 : 32'd4);
         end
         if (imem_req_o) begin
            r_fetch_addr <= r_fetch_addr + ADDR_WIDTH'(4);
         end
         if (r_rsp_pending && r_drop_low) begin
            r_drop_low <= 1'b0;
         end
         r_rsp_pending <= imem_req_o;
      end
   end

endmodule

// File: tb/tb_instruction_aligner.sv
// Randomized scoreboard bench: a program-order walk over the memory image predicts
// the instruction stream; a negedge monitor checks every accepted instruction.
module tb_instruction_aligner;

   localparam logic [31:0] RESET_PC = 32'h0000_0002;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_c;

   logic [31:0] mem [256];

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        c;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   instruction_aligner #(.RESET_PC(RESET_PC), .ADDR_WIDTH(32)) dut (
      .clk              (clk),
      .reset            (reset),
      .imem_req_o       (imem_req),
      .imem_addr_o      (imem_addr),
      .imem_rdata_i     (imem_rdata),
      .flush_i          (flush),
      .flush_pc_i       (flush_pc),
      .out_valid_o      (out_valid),
      .out_ready_i      (out_ready),
      .out_instr_o      (out_instr),
      .out_pc_o         (out_pc),
      .out_compressed_o (out_c)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (imem_req) imem_rdata <= mem[imem_addr[9:2]];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   function automatic logic [15:0] hw_at(input logic [31:0] pc);
      logic [31:0] w;
      w = mem[pc[9:2]];
      return pc[1] ? w[31:16] : w[15:0];
   endfunction

   // Walk the program from a PC and queue the instructions it should produce
   task automatic append_stream(input logic [31:0] start, input int n);
      logic [31:0] pc;
      logic [15:0] h;
      pc = start;
      for (int i = 0; i < n; i++) begin
         h = hw_at(pc);
         if (h[1:0] != 2'b11) begin
            exp_q.push_back('{instr: {16'h0000, h}, pc: pc, c: 1'b1});
            pc = pc + 32'd2;
         end else begin
            exp_q.push_back('{instr: {hw_at(pc + 32'd2), h}, pc: pc, c: 1'b0});
            pc = pc + 32'd4;
         end
      end
   endtask

   function automatic logic [15:0] rand_hw();
      logic [15:0] h;
      h = 16'($urandom);
      if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
      else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
      return h;
   endfunction

   // Monitor: scoreboard pops on every accepted instruction; stalled outputs must hold
   initial begin : monitor
      logic        hold_q;
      logic [31:0] hold_instr;
      logic [31:0] hold_pc;
      logic        hold_c;
      exp_t        e;
      hold_q = 1'b0;
      hold_instr = '0;
      hold_pc = '0;
      hold_c = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            hold_q = 1'b0;
         end else begin
            if (hold_q && !flush) begin
               check("hold_instr", out_instr, hold_instr);
               check("hold_pc", out_pc, hold_pc);
               check("hold_c", {31'b0, out_c}, {31'b0, hold_c});
            end
            if (out_valid && out_ready) begin
               $display("txn pc=%h instr=%h c=%0d", out_pc, out_instr, out_c);
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL scoreboard_empty: got pc %h want no output", out_pc);
               end else begin
                  e = exp_q.pop_front();
                  check("instr", out_instr, e.instr);
                  check("pc", out_pc, e.pc);
                  check("compressed", {31'b0, out_c}, {31'b0, e.c});
               end
            end
            hold_q = out_valid && !out_ready;
            hold_instr = out_instr;
            hold_pc = out_pc;
            hold_c = out_c;
         end
      end
   end

   task automatic run_random(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1 out_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic flush_to(input logic [31:0] t);
      @(posedge clk);
      #1;
      flush = 1'b1;
      flush_pc = t;
      out_ready = 1'b1;
      exp_q.delete();
      append_stream(t, 100);
      #1;
      check("flush_req_suppressed", {31'b0, imem_req}, 32'd0);
      check("flush_valid_forced", {31'b0, out_valid}, 32'd0);
      @(posedge clk);
      #1 flush = 1'b0;
      #1;
      check("post_flush_req", {31'b0, imem_req}, 32'd1);
      check("post_flush_addr", imem_addr, t & ~32'h3);
   endtask

   task automatic reset_pulse();
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      append_stream(RESET_PC, 100);
      #1;
      check("reset_req_low", {31'b0, imem_req}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("post_reset_valid", {31'b0, out_valid}, 32'd0);
      check("post_reset_req", {31'b0, imem_req}, 32'd1);
      check("post_reset_addr", imem_addr, RESET_PC & ~32'h3);
   endtask

   initial begin : stimulus
      for (int i = 0; i < 256; i++) mem[i] = {rand_hw(), rand_hw()};
      mem[0] = 32'h00A0_0093;
      mem[1] = 32'h4505_0511;
      mem[2] = 32'h0093_0505;
      mem[3] = 32'h0000_00A0;

      // Reset state, then the halfword-aligned reset PC
      exp_q.delete();
      append_stream(RESET_PC, 100);
      repeat (2) @(posedge clk);
      #2;
      check("rst_valid", {31'b0, out_valid}, 32'd0);
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_instr", out_instr, 32'd0);
      check("rst_c", {31'b0, out_c}, 32'd0);
      check("rst_pc", out_pc, RESET_PC);
      @(posedge clk);
      #1 reset = 1'b0;
      out_ready = 1'b1;
      #1;
      check("first_req", {31'b0, imem_req}, 32'd1);
      check("first_addr", imem_addr, 32'h0);
      run_random(40);

      // Aligned start with a known 32/16/16 sequence and exact latency
      flush_to(32'h0);
      exp_q.delete();
      exp_q.push_back('{instr: 32'h00A0_0093, pc: 32'h0, c: 1'b0});
      exp_q.push_back('{instr: 32'h0000_0511, pc: 32'h4, c: 1'b1});
      exp_q.push_back('{instr: 32'h0000_4505, pc: 32'h6, c: 1'b1});
      append_stream(32'h8, 90);
      @(posedge clk);
      #2 check("latency_not_yet", {31'b0, out_valid}, 32'd0);
      @(posedge clk);
      #2 check("latency_valid", {31'b0, out_valid}, 32'd1);
      repeat (5) @(posedge clk);

      // 32-bit instruction straddling a word boundary
      flush_to(32'h8);
      exp_q.delete();
      exp_q.push_back('{instr: 32'h0000_0505, pc: 32'h8, c: 1'b1});
      exp_q.push_back('{instr: 32'h00A0_0093, pc: 32'hA, c: 1'b0});
      append_stream(32'hE, 90);
      repeat (6) @(posedge clk);

      // Backpressure: hold six cycles, fetch must throttle
      run_random(10);
      @(posedge clk);
      #1 out_ready = 1'b0;
      repeat (6) @(posedge clk);
      #2 check("stall_req_throttled", {31'b0, imem_req}, 32'd0);
      run_random(20);

      // Redirect to a halfword target while a response is in flight
      flush_to(32'h0000_0102);
      run_random(30);

      // PC wrap across 2^32
      flush_to(32'hFFFF_FFFA);
      run_random(30);

      // Mid-stream reset
      run_random(15);
      reset_pulse();
      run_random(30);

      for (int k = 0; k < 20; k++) begin
         case ($urandom_range(0, 3))
            0:       reset_pulse();
            1, 2:    flush_to($urandom & 32'hFFFF_FFFE);
            default: ;
         endcase
         run_random($urandom_range(5, 60));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
